// File: rtl/demux_feeder.sv
// demux_feeder: 4-entry FIFO feeding a 1-to-4 demux, DWELL cycles per bit.
// Define DEMUX_FEEDER_PARK_Z_EN to float s1/s0/out_data while idle.
module demux_feeder #(
  parameter int DWELL = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_dest,
  input  logic       req_data,
  output logic       s1,
  output logic       s0,
  output logic       out_data,
  output logic       busy,
  output logic [2:0] count
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t     state_q;
  logic [2:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [3:0] dwell_q;
  logic [1:0] sel_q;
  logic       data_q;
  logic       push;
  logic       pop;

  assign req_ready = (count_q != 3'd4);
  assign busy      = (state_q == HOLD);
  assign count     = count_q;

  // Handshake, pop decision and next pointer/occupancy values
  always_comb begin
    push     = req_valid && req_ready;
    pop      = (count_q != 3'd0) &&
               ((state_q == IDLE) || (dwell_q == 4'd0));
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
  end

  // FIFO storage and pointers; reset discards contents
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= {req_dest, req_data};
    end
  end

  // Two-state hold FSM with registered select and data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dwell_q <= 4'd0;
      sel_q   <= 2'b00;
      data_q  <= 1'b0;
    end else if (pop) begin
      state_q <= HOLD;
      dwell_q <= 4'(DWELL - 1);
      sel_q   <= mem_q[rd_ptr_q][2:1];
      data_q  <= mem_q[rd_ptr_q][0];
    end else begin
      unique case (state_q)
        HOLD: begin
          if (dwell_q != 4'd0) begin
            dwell_q <= dwell_q - 4'd1;
          end else begin
            state_q <= IDLE;
            data_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DEMUX_FEEDER_PARK_Z_EN
  assign s1       = busy ? sel_q[1] : 1'bz;
  assign s0       = busy ? sel_q[0] : 1'bz;
  assign out_data = busy ? data_q   : 1'bz;
`else
  assign s1       = sel_q[1];
  assign s0       = sel_q[0];
  assign out_data = data_q;
`endif

endmodule

// File: tb/tb_demux_feeder.sv
// tb_demux_feeder: directed checks of demux_feeder at DWELL 2, 4 and 1.
// Honours DEMUX_FEEDER_PARK_Z_EN for the expected idle values.
module tb_demux_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] vld, dat, rdy, s1, s0, od, bz;
  logic [1:0] dst [3];
  logic [2:0] cnt [3];
  int         n_err = 0;
  int         n_chk = 0;

`ifdef DEMUX_FEEDER_PARK_Z_EN
  localparam logic IDLE_D = 1'bz;
`else
  localparam logic IDLE_D = 1'b0;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    demux_feeder #(
      .DWELL(g == 0 ? 2 : (g == 1 ? 4 : 1))
    ) u_dut (
      .clock    (clk),
      .reset    (rst_n),
      .req_valid(vld[g]),
      .req_ready(rdy[g]),
      .req_dest (dst[g]),
      .req_data (dat[g]),
      .s1       (s1[g]),
      .s0       (s0[g]),
      .out_data (od[g]),
      .busy     (bz[g]),
      .count    (cnt[g])
    );
  end

  function automatic logic [1:0] exp_s(input logic [1:0] last);
`ifdef DEMUX_FEEDER_PARK_Z_EN
    exp_s = 2'bzz;
`else
    exp_s = last;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] t2 [6];
  logic [2:0] t4 [4];
  logic [2:0] trace [$];
  logic [2:0] it;
  int         i, first, last, maxc;
  logic       acc, saw_full;

  initial begin
    t2 = '{3'b001, 3'b010, 3'b101, 3'b111, 3'b000, 3'b101};
    t4 = '{3'b011, 3'b101, 3'b110, 3'b001};
    vld = '0;
    dat = '0;
    for (int g = 0; g < 3; g++) dst[g] = 2'd0;
    #12;
    chk("rst_ready", {7'd0, rdy[0]}, 8'd1);
    chk("rst_count", {5'd0, cnt[0]}, 8'd0);
    chk("rst_busy", {7'd0, bz[0]}, 8'd0);
    chk("rst_sel", {6'd0, s1[0], s0[0]}, {6'd0, exp_s(2'b00)});
    chk("rst_data", {7'd0, od[0]}, {7'd0, IDLE_D});

    // single push, DWELL=2
    @(negedge clk);
    rst_n = 1'b1;
    vld[0] = 1'b1;
    dst[0] = 2'd2;
    dat[0] = 1'b1;
    step;
    vld[0] = 1'b0;
    chk("t1_push_cnt", {5'd0, cnt[0]}, 8'd1);
    chk("t1_push_busy", {7'd0, bz[0]}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      step;
      if (k < 2) begin
        chk("t1_busy", {7'd0, bz[0]}, 8'd1);
        chk("t1_sel", {6'd0, s1[0], s0[0]}, 8'd2);
        chk("t1_data", {7'd0, od[0]}, 8'd1);
      end else begin
        chk("t1_idle_busy", {7'd0, bz[0]}, 8'd0);
        chk("t1_idle_sel", {6'd0, s1[0], s0[0]},
            {6'd0, exp_s(2'b10)});
        chk("t1_idle_data", {7'd0, od[0]}, {7'd0, IDLE_D});
      end
    end

    // back-to-back pushes into a DWELL=4 sink
    i = 0; first = -1; last = -1; maxc = 0; saw_full = 1'b0;
    trace.delete();
    for (int c = 0; c < 80; c++) begin
      if (i < 6) begin
        vld[1] = 1'b1;
        it = t2[i];
        dst[1] = it[2:1];
        dat[1] = it[0];
      end else begin
        vld[1] = 1'b0;
      end
      acc = vld[1] && rdy[1];
      if (vld[1] && !rdy[1]) saw_full = 1'b1;
      step;
      if (acc) i++;
      if (int'(cnt[1]) > maxc) maxc = int'(cnt[1]);
      if (bz[1]) begin
        trace.push_back({s1[1], s0[1], od[1]});
        if (first < 0) first = c;
        last = c;
      end
    end
    vld[1] = 1'b0;
    chk("t2_full_seen", {7'd0, saw_full}, 8'd1);
    chk("t2_max_cnt", 8'(maxc), 8'd4);
    chk("t2_all_pushed", 8'(i), 8'd6);
    chk("t2_len", 8'(trace.size()), 8'd24);
    chk("t2_contig", 8'(last - first + 1), 8'd24);
    for (int j = 0; j < 24 && j < trace.size(); j++)
      chk("t2_order", {5'd0, trace[j]}, {5'd0, t2[j / 4]});

    // continuous pushes, DWELL=1
    i = 0; first = -1; last = -1;
    trace.delete();
    for (int c = 0; c < 20; c++) begin
      if (i < 8) begin
        vld[2] = 1'b1;
        dst[2] = 2'(i);
        dat[2] = i[2];
      end else begin
        vld[2] = 1'b0;
      end
      acc = vld[2] && rdy[2];
      step;
      if (acc) i++;
      if (c <= 7) chk("t3_cnt", {5'd0, cnt[2]}, 8'd1);
      if (c == 8) chk("t3_drain", {5'd0, cnt[2]}, 8'd0);
      if (bz[2]) begin
        trace.push_back({s1[2], s0[2], od[2]});
        if (first < 0) first = c;
        last = c;
      end
    end
    vld[2] = 1'b0;
    chk("t3_len", 8'(trace.size()), 8'd8);
    chk("t3_contig", 8'(last - first + 1), 8'd8);
    for (int j = 0; j < 8 && j < trace.size(); j++) begin
      it = {2'(j), 1'(j >> 2)};
      chk("t3_order", {5'd0, trace[j]}, {5'd0, it});
    end

    // reset mid-HOLD with three entries queued
    for (int k = 0; k < 4; k++) begin
      vld[1] = 1'b1;
      it = t4[k];
      dst[1] = it[2:1];
      dat[1] = it[0];
      step;
    end
    vld[1] = 1'b0;
    chk("t4_pre_cnt", {5'd0, cnt[1]}, 8'd3);
    chk("t4_pre_busy", {7'd0, bz[1]}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_cnt", {5'd0, cnt[1]}, 8'd0);
    chk("t4_rst_busy", {7'd0, bz[1]}, 8'd0);
    chk("t4_rst_rdy", {7'd0, rdy[1]}, 8'd1);
    chk("t4_rst_sel", {6'd0, s1[1], s0[1]}, {6'd0, exp_s(2'b00)});
    chk("t4_rst_data", {7'd0, od[1]}, {7'd0, IDLE_D});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vld[1] = 1'b1;
    dst[1] = 2'd1;
    dat[1] = 1'b1;
    step;
    vld[1] = 1'b0;
    chk("t4_first_push", {5'd0, cnt[1]}, 8'd1);
    step;
    chk("t4_hold_busy", {7'd0, bz[1]}, 8'd1);
    chk("t4_hold_sel", {6'd0, s1[1], s0[1]}, 8'd1);
    chk("t4_hold_data", {7'd0, od[1]}, 8'd1);
    chk("t4_no_stale", {5'd0, cnt[1]}, 8'd0);
    step; step; step;
    chk("t4_hold_end", {7'd0, bz[1]}, 8'd1);
    step;
    chk("t4_idle_busy", {7'd0, bz[1]}, 8'd0);
    chk("t4_idle_sel", {6'd0, s1[1], s0[1]}, {6'd0, exp_s(2'b01)});
    chk("t4_idle_data", {7'd0, od[1]}, {7'd0, IDLE_D});
    chk("t4_idle_cnt", {5'd0, cnt[1]}, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
